// File: rtl/aud_pkg.sv
// Shared audio-path definitions: FSM state encoding and default widths,
// common to the I2S player and recorder.
package aud_pkg;

   localparam int AUD_ADDR_W = 20;
   localparam int AUD_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_LRC = 3'd1,
      SHIFT    = 3'd2,
      TAIL     = 3'd3,
      PAUSED   = 3'd4
   } aud_state_e;

   function automatic logic is_playing(input aud_state_e s);
      return (s == WAIT_LRC) || (s == SHIFT) || (s == TAIL);
   endfunction

endpackage

// File: rtl/aud_player_if.sv
// Control, SRAM-read and DAC-data signals of the I2S player.
// The player uses the slave side; the control FSM / SRAM mux uses the master side.
interface aud_player_if #(
   parameter int ADDR_W = aud_pkg::AUD_ADDR_W,
   parameter int DATA_W = aud_pkg::AUD_DATA_W
);

   logic              i_lrc;
   logic              i_start;
   logic              i_pause;
   logic              i_stop;
   logic [ADDR_W-1:0] i_end_addr;
   logic [DATA_W-1:0] i_sram_data;
   logic [ADDR_W-1:0] o_address;
   logic              o_dacdat;
   logic              o_playing;
   logic              o_done;

   modport slave (
      input  i_lrc, i_start, i_pause, i_stop, i_end_addr, i_sram_data,
      output o_address, o_dacdat, o_playing, o_done
   );

   modport master (
      output i_lrc, i_start, i_pause, i_stop, i_end_addr, i_sram_data,
      input  o_address, o_dacdat, o_playing, o_done
   );

endinterface

// File: rtl/aud_i2s_serializer.sv
// Load/shift register with bit counter: emits one word MSB-first on a registered
// serial output and flags the cycle that drives the final bit.
module aud_i2s_serializer #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] din,
   output logic              sdo,
   output logic              last_bit
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] shreg_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              sdo_r;

   // Shift register, bit counter and output bit; the output idles low between words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_r <= {DATA_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         sdo_r   <= 1'b0;
      end else if (clear) begin
         shreg_r <= {DATA_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         sdo_r   <= 1'b0;
      end else if (load) begin
         shreg_r <= din;
         cnt_r   <= {CNT_W{1'b0}};
         sdo_r   <= 1'b0;
      end else if (shift) begin
         shreg_r <= {shreg_r[DATA_W-2:0], 1'b0};
         cnt_r   <= cnt_r + CNT_W'(1'b1);
         sdo_r   <= shreg_r[DATA_W-1];
      end else begin
         sdo_r   <= 1'b0;
      end
   end

   assign sdo      = sdo_r;
   assign last_bit = (cnt_r == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/aud_player.sv
// I2S playback engine: walks SRAM from address 0 to the end address and sends
// each sample MSB-first in the left-channel slot, with pause/resume and abort.
module aud_player
   import aud_pkg::*;
#(
   parameter int ADDR_W = AUD_ADDR_W,
   parameter int DATA_W = AUD_DATA_W
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   aud_player_if.slave bus
);

   aud_state_e        state_r, state_nx;
   logic [ADDR_W-1:0] addr_r, addr_nx;
   logic              pause_req_r, pause_nx;
   logic              done_r, done_nx;
   logic              playing_r;
   logic              lrc_d_r;
   logic              lrc_fall_s;
   logic              pause_hit_s;
   logic              load_s, shift_s, clear_s;
   logic              last_bit_s, sdo_s;

   assign lrc_fall_s = lrc_d_r & ~bus.i_lrc;

   aud_i2s_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .clear    (clear_s),
      .load     (load_s),
      .shift    (shift_s),
      .din      (bus.i_sram_data),
      .sdo      (sdo_s),
      .last_bit (last_bit_s)
   );

   // Next-state, address and pause bookkeeping; stop overrides everything.
   always_comb begin
      state_nx    = state_r;
      addr_nx     = addr_r;
      pause_nx    = pause_req_r;
      done_nx     = 1'b0;
      load_s      = 1'b0;
      shift_s     = 1'b0;
      clear_s     = 1'b0;
      pause_hit_s = pause_req_r | bus.i_pause;
      if (bus.i_stop) begin
         state_nx = IDLE;
         addr_nx  = {ADDR_W{1'b0}};
         pause_nx = 1'b0;
         clear_s  = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               pause_nx = 1'b0;
               if (bus.i_start) begin
                  state_nx = WAIT_LRC;
                  addr_nx  = {ADDR_W{1'b0}};
               end else begin
                  state_nx = IDLE;
               end
            end
            WAIT_LRC, TAIL: begin
               pause_nx = pause_hit_s;
               if (lrc_fall_s) begin
                  load_s   = 1'b1;
                  state_nx = SHIFT;
               end else begin
                  state_nx = state_r;
               end
            end
            SHIFT: begin
               shift_s  = 1'b1;
               pause_nx = pause_hit_s;
               if (last_bit_s) begin
                  pause_nx = 1'b0;
                  if (addr_r == bus.i_end_addr) begin
                     done_nx  = 1'b1;
                     addr_nx  = {ADDR_W{1'b0}};
                     state_nx = IDLE;
                  end else begin
                     // Address advances before a pause so resume starts on the next word.
                     addr_nx  = addr_r + ADDR_W'(1'b1);
                     state_nx = pause_hit_s ? PAUSED : TAIL;
                  end
               end else begin
                  state_nx = SHIFT;
               end
            end
            PAUSED: begin
               pause_nx = 1'b0;
               if (bus.i_pause) begin
                  state_nx = PAUSED;
               end else if (bus.i_start) begin
                  state_nx = WAIT_LRC;
               end else begin
                  state_nx = PAUSED;
               end
            end
            default: begin
               state_nx = IDLE;
               addr_nx  = {ADDR_W{1'b0}};
               pause_nx = 1'b0;
               clear_s  = 1'b1;
            end
         endcase
      end
   end

   // State, address, flags and LRC history registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         pause_req_r <= 1'b0;
         done_r      <= 1'b0;
         playing_r   <= 1'b0;
         lrc_d_r     <= 1'b1;
      end else begin
         state_r     <= state_nx;
         addr_r      <= addr_nx;
         pause_req_r <= pause_nx;
         done_r      <= done_nx;
         playing_r   <= is_playing(state_nx);
         lrc_d_r     <= bus.i_lrc;
      end
   end

   assign bus.o_address = addr_r;
   assign bus.o_dacdat  = sdo_s;
   assign bus.o_playing = playing_r;
   assign bus.o_done    = done_r;

endmodule
